dmem_loader: RTL

DMEM_LOADER -- requirements
Module: dmem_loader

---
 rtl/dmem_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_loader.sv
// Byte-stream loader/dumper for a 32-bit data memory: assembles inbound bytes into
// little-endian words and writes them, or reads words and streams them out LSB first.
module dmem_loader #(
  parameter int DEPTH      = 512,
  parameter int START_ADDR = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        start_dump,
  input  logic [9:0]  word_count,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LD_BYTE, LD_WRITE, DP_READ, DP_SEND, FINISH
  } state_t;

  localparam logic [9:0] BASE = 10'(START_ADDR);

  state_t      state, state_nxt;
  logic [9:0]  cnt, idx;
  logic [1:0]  bidx;
  logic [31:0] word, sreg;
  logic [11:0] span;
  logic        range_bad, last_word, start_any;

  assign span      = 12'(START_ADDR) + {2'b00, word_count};
  assign range_bad = span > 12'(DEPTH);
  assign last_word = (idx + 10'd1) == cnt;
  assign start_any = start_load | start_dump;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        // start_load wins when both starts arrive together
        if (start_any && !range_bad) begin
          if (word_count == '0)  state_nxt = FINISH;
          else if (start_load)   state_nxt = LD_BYTE;
          else                   state_nxt = DP_READ;
        end
      end
      LD_BYTE: begin
        rx_ready = 1'b1;
        if (rx_valid && bidx == 2'd3) state_nxt = LD_WRITE;
      end
      LD_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = BASE + idx;
        mem_din   = word;
        state_nxt = last_word ? FINISH : LD_BYTE;
      end
      DP_READ: begin
        mem_addr  = BASE + idx;
        state_nxt = DP_SEND;
      end
      DP_SEND: begin
        tx_valid = 1'b1;
        tx_data  = sreg[7:0];
        if (tx_ready && bidx == 2'd3) state_nxt = last_word ? FINISH : DP_READ;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      bidx <= '0;
      word <= '0;
      sreg <= '0;
      err  <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_any) begin
            if (range_bad) begin
              err <= 1'b1;
            end else begin
              cnt  <= word_count;
              idx  <= '0;
              bidx <= '0;
            end
          end
        end
        LD_BYTE: begin
          if (rx_valid) begin
            word[{bidx, 3'b000} +: 8] <= rx_data;
            bidx <= bidx + 2'd1;
          end
        end
        LD_WRITE: idx <= idx + 10'd1;
        DP_READ:  sreg <= mem_dout;
        DP_SEND: begin
          if (tx_ready) begin
            sreg <= sreg >> 8;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) idx <= idx + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
